cbfp_pack: RTL and testbench

Block-floating-point packer that produces the 11-bit `<5.6>` sample stream consumed by the radix-2 butterfly/twiddle stage. It sits upstream of that stage and forms the transmitting end of its 16-lane data/valid interface. It accepts wide twiddle-multiplier results, buffers each block in a ping-pong memory, and finds the block-wide minimum leading-sign count. It then emits the block left-normalised and truncated to `OUT_WIDTH`, together with the block exponent.

---
 rtl/cbfp_pkg.sv | 40 ++++
 rtl/cbfp_pack_lsc_min.sv | 30 +++
 rtl/cbfp_pack.sv | 277 +++++++++++++++++++++++++++
 tb/tb_cbfp_pack.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/cbfp_pkg.sv
// cbfp_pkg: shared constants, read-state type and leading-sign-count helper
// for the block-floating-point packer.
package cbfp_pkg;

    localparam int unsigned IN_W_DEF  = 23;
    localparam int unsigned OUT_W_DEF = 11;
    localparam int unsigned LANES_DEF = 16;
    localparam int unsigned BLK_DEF   = 4;
    localparam int unsigned EXP_W     = $clog2(IN_W_DEF);

    // Widest sample the lsc helper can inspect
    localparam int unsigned LSC_MAXW  = 64;

    typedef enum logic {
        IDLE,
        DRAIN
    } rd_state_t;

    // Count of bits directly below the sign bit that equal the sign bit.
    // The caller passes the sample zero-extended to LSC_MAXW and its true width.
    function automatic int unsigned lsc(input logic [LSC_MAXW-1:0] x, input int unsigned w);
        logic        sgn;
        logic        run;
        int unsigned n;
        sgn = x[6'(w - 1)];
        run = 1'b1;
        n   = 0;
        for (int unsigned i = 1; i < LSC_MAXW; i++) begin
            if (i < w) begin
                if (run && (x[6'(w - 1 - i)] == sgn)) begin
                    n = n + 1;
                end else begin
                    run = 1'b0;
                end
            end
        end
        return n;
    endfunction

endpackage

// File: rtl/cbfp_pack_lsc_min.sv
// lsc_min: leading-sign count of every re/im value of one beat, reduced to
// the beat-wide minimum.
module lsc_min
    import cbfp_pkg::*;
#(
    parameter int unsigned IN_WIDTH = IN_W_DEF,
    parameter int unsigned LANES    = LANES_DEF,
    parameter int unsigned E_W      = $clog2(IN_WIDTH)
) (
    input  logic [IN_WIDTH-1:0] re [0:LANES-1],
    input  logic [IN_WIDTH-1:0] im [0:LANES-1],
    output logic [E_W-1:0]      beat_min
);

    // Minimum of lsc over all 2*LANES values, starting from the largest possible count
    always_comb begin
        logic [E_W-1:0] m;
        logic [E_W-1:0] a;
        logic [E_W-1:0] b;
        m = E_W'(IN_WIDTH - 1);
        for (int unsigned l = 0; l < LANES; l++) begin
            a = E_W'(lsc(LSC_MAXW'(re[l]), IN_WIDTH));
            b = E_W'(lsc(LSC_MAXW'(im[l]), IN_WIDTH));
            if (a < m) m = a;
            if (b < m) m = b;
        end
        beat_min = m;
    end

endmodule

// File: rtl/cbfp_pack.sv
// cbfp_pack: buffers blocks of LANES x BLK_CYCLES complex samples in a
// ping-pong memory, finds the block-wide minimum leading-sign count and emits
// the block left-normalised to OUT_WIDTH bits with its block exponent.
// Optional feature: define CBFP_ROUND_EN for round-half-up with saturation
// (adds one output pipeline stage).
module cbfp_pack
    import cbfp_pkg::*;
#(
    parameter int unsigned IN_WIDTH   = IN_W_DEF,
    parameter int unsigned OUT_WIDTH  = OUT_W_DEF,
    parameter int unsigned LANES      = LANES_DEF,
    parameter int unsigned BLK_CYCLES = BLK_DEF
) (
    input  logic                        clk,
    input  logic                        rstn,
    input  logic [IN_WIDTH-1:0]         din_re [0:LANES-1],
    input  logic [IN_WIDTH-1:0]         din_im [0:LANES-1],
    input  logic                        din_valid,
    output logic [OUT_WIDTH-1:0]        dout_re [0:LANES-1],
    output logic [OUT_WIDTH-1:0]        dout_im [0:LANES-1],
    output logic                        dout_valid,
    output logic                        dout_sop,
    output logic [$clog2(IN_WIDTH)-1:0] dout_exp,
    output logic                        blk_err
);

    localparam int unsigned E_W = $clog2(IN_WIDTH);
    localparam int unsigned CW  = (BLK_CYCLES > 1) ? $clog2(BLK_CYCLES) : 1;
    localparam int unsigned SH  = IN_WIDTH - OUT_WIDTH;
    localparam logic [CW-1:0]  LAST    = CW'(BLK_CYCLES - 1);
    localparam logic [E_W-1:0] LSC_MAX = E_W'(IN_WIDTH - 1);

    logic [IN_WIDTH-1:0] mem_re [0:1][0:BLK_CYCLES-1][0:LANES-1];
    logic [IN_WIDTH-1:0] mem_im [0:1][0:BLK_CYCLES-1][0:LANES-1];

    logic [CW-1:0]       wcnt;
    logic                wbank;
    logic [E_W-1:0]      rmin;
    logic [E_W-1:0]      beat_min;
    logic [E_W-1:0]      blk_min;
    logic [1:0]          full;
    logic [1:0][E_W-1:0] exps;

    rd_state_t           state;
    rd_state_t           state_n;
    logic [CW-1:0]       rcnt;
    logic [CW-1:0]       rcnt_n;
    logic                rbank;
    logic                rbank_n;
    logic                rd_en;
    logic                drain_done;
    logic [E_W-1:0]      rd_exp;

    lsc_min #(
        .IN_WIDTH (IN_WIDTH),
        .LANES    (LANES),
        .E_W      (E_W)
    ) u_lsc_min (
        .re       (din_re),
        .im       (din_im),
        .beat_min (beat_min)
    );

    // Running minimum including the current beat
    always_comb begin
        blk_min = (beat_min < rmin) ? beat_min : rmin;
    end

    // Sample storage; contents need no reset because the full flags gate reading
    always_ff @(posedge clk) begin
        if (din_valid) begin
            for (int unsigned l = 0; l < LANES; l++) begin
                mem_re[wbank][wcnt][l] <= din_re[l];
                mem_im[wbank][wcnt][l] <= din_im[l];
            end
        end
    end

    // Write-side control: beat counter, running minimum, bank exponent, full flags, truncation
    always_ff @(posedge clk) begin
        if (rstn) begin
            wcnt    <= '0;
            wbank   <= 1'b0;
            rmin    <= LSC_MAX;
            exps    <= '0;
            full    <= '0;
            blk_err <= 1'b0;
        end else begin
            blk_err <= 1'b0;
            if (din_valid) begin
                if (wcnt == LAST) begin
                    wcnt        <= '0;
                    wbank       <= ~wbank;
                    rmin        <= LSC_MAX;
                    exps[wbank] <= blk_min;
                end else begin
                    wcnt <= wcnt + 1'b1;
                    rmin <= blk_min;
                end
            end else if (wcnt != '0) begin
                wcnt    <= '0;
                rmin    <= LSC_MAX;
                blk_err <= 1'b1;
            end
            if (drain_done) begin
                full[rbank] <= 1'b0;
            end
            if (din_valid && (wcnt == LAST)) begin
                full[wbank] <= 1'b1;
            end
        end
    end

    // Read FSM state register
    always_ff @(posedge clk) begin
        if (rstn) begin
            state <= IDLE;
            rcnt  <= '0;
            rbank <= 1'b0;
        end else begin
            state <= state_n;
            rcnt  <= rcnt_n;
            rbank <= rbank_n;
        end
    end

    // Read FSM next state: drain a full bank, chaining straight into the other if it is full
    always_comb begin
        state_n    = state;
        rcnt_n     = rcnt;
        rbank_n    = rbank;
        rd_en      = 1'b0;
        drain_done = 1'b0;
        unique case (state)
            IDLE: begin
                if (full != 2'b00) begin
                    state_n = DRAIN;
                    rcnt_n  = '0;
                    rbank_n = full[rbank] ? rbank : ~rbank;
                end
            end
            DRAIN: begin
                rd_en = 1'b1;
                if (rcnt == LAST) begin
                    drain_done = 1'b1;
                    rcnt_n     = '0;
                    rbank_n    = ~rbank;
                    state_n    = full[~rbank] ? DRAIN : IDLE;
                end else begin
                    rcnt_n = rcnt + 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // Exponent of the bank being drained
    always_comb begin
        rd_exp = exps[rbank];
    end

`ifdef CBFP_ROUND_EN
    localparam int unsigned       SW   = IN_WIDTH + 1;
    localparam logic signed [SW-1:0] HALF = SW'(2 ** (SH - 1));
    localparam logic signed [SW-1:0] SMAX = SW'(2 ** (OUT_WIDTH - 1) - 1);
    localparam logic signed [SW-1:0] SMIN = -SMAX - 1;

    logic [IN_WIDTH-1:0] sc_re [0:LANES-1];
    logic [IN_WIDTH-1:0] sc_im [0:LANES-1];
    logic [IN_WIDTH-1:0] p_re  [0:LANES-1];
    logic [IN_WIDTH-1:0] p_im  [0:LANES-1];
    logic                p_valid;
    logic                p_sop;
    logic [E_W-1:0]      p_exp;

    function automatic logic [OUT_WIDTH-1:0] rnd(input logic [IN_WIDTH-1:0] x);
        logic signed [SW-1:0] s;
        logic signed [SW-1:0] q;
        s = $signed({x[IN_WIDTH-1], x}) + HALF;
        q = s >>> SH;
        if (q > SMAX) begin
            rnd = SMAX[OUT_WIDTH-1:0];
        end else if (q < SMIN) begin
            rnd = SMIN[OUT_WIDTH-1:0];
        end else begin
            rnd = q[OUT_WIDTH-1:0];
        end
    endfunction

    // Full-width normalisation of the row being drained
    always_comb begin
        for (int unsigned l = 0; l < LANES; l++) begin
            sc_re[l] = mem_re[rbank][rcnt][l] << rd_exp;
            sc_im[l] = mem_im[rbank][rcnt][l] << rd_exp;
        end
    end

    // First output stage: register the full-width scaled row ahead of rounding
    always_ff @(posedge clk) begin
        if (rstn) begin
            p_valid <= 1'b0;
            p_sop   <= 1'b0;
            p_exp   <= '0;
            for (int unsigned l = 0; l < LANES; l++) begin
                p_re[l] <= '0;
                p_im[l] <= '0;
            end
        end else begin
            p_valid <= rd_en;
            p_sop   <= rd_en && (rcnt == '0);
            if (rd_en && (rcnt == '0)) begin
                p_exp <= rd_exp;
            end
            for (int unsigned l = 0; l < LANES; l++) begin
                p_re[l] <= rd_en ? sc_re[l] : '0;
                p_im[l] <= rd_en ? sc_im[l] : '0;
            end
        end
    end

    // Second output stage: round half-up and saturate to OUT_WIDTH
    always_ff @(posedge clk) begin
        if (rstn) begin
            dout_valid <= 1'b0;
            dout_sop   <= 1'b0;
            dout_exp   <= '0;
            for (int unsigned l = 0; l < LANES; l++) begin
                dout_re[l] <= '0;
                dout_im[l] <= '0;
            end
        end else begin
            dout_valid <= p_valid;
            dout_sop   <= p_sop;
            dout_exp   <= p_exp;
            for (int unsigned l = 0; l < LANES; l++) begin
                dout_re[l] <= p_valid ? rnd(p_re[l]) : '0;
                dout_im[l] <= p_valid ? rnd(p_im[l]) : '0;
            end
        end
    end
`else
    logic [OUT_WIDTH-1:0] tr_re [0:LANES-1];
    logic [OUT_WIDTH-1:0] tr_im [0:LANES-1];

    // Normalise and keep the top OUT_WIDTH bits; the shift never exceeds the lsc so nothing overflows
    always_comb begin
        for (int unsigned l = 0; l < LANES; l++) begin
            tr_re[l] = OUT_WIDTH'((mem_re[rbank][rcnt][l] << rd_exp) >> SH);
            tr_im[l] = OUT_WIDTH'((mem_im[rbank][rcnt][l] << rd_exp) >> SH);
        end
    end

    // Output register; exponent reloads only at start of block
    always_ff @(posedge clk) begin
        if (rstn) begin
            dout_valid <= 1'b0;
            dout_sop   <= 1'b0;
            dout_exp   <= '0;
            for (int unsigned l = 0; l < LANES; l++) begin
                dout_re[l] <= '0;
                dout_im[l] <= '0;
            end
        end else begin
            dout_valid <= rd_en;
            dout_sop   <= rd_en && (rcnt == '0);
            if (rd_en && (rcnt == '0)) begin
                dout_exp <= rd_exp;
            end
            for (int unsigned l = 0; l < LANES; l++) begin
                dout_re[l] <= rd_en ? tr_re[l] : '0;
                dout_im[l] <= rd_en ? tr_im[l] : '0;
            end
        end
    end
`endif

endmodule

// File: tb/tb_cbfp_pack.sv
// tb_cbfp_pack: table-driven, scoreboard-checked bench for cbfp_pack.
module tb_cbfp_pack;

    localparam int IW = 23;
    localparam int OW = 11;
    localparam int L  = 16;
    localparam int B  = 4;
`ifdef CBFP_ROUND_EN
    localparam int LAT   = B + 2;
    localparam int R6143 = 768;
    localparam int R100  = 13;
`else
    localparam int LAT   = B + 1;
    localparam int R6143 = 767;
    localparam int R100  = 12;
`endif

    logic          clk = 1'b0;
    logic          rstn = 1'b1;
    logic          din_valid = 1'b0;
    logic [IW-1:0] din_re [0:L-1];
    logic [IW-1:0] din_im [0:L-1];
    logic [OW-1:0] dout_re [0:L-1];
    logic [OW-1:0] dout_im [0:L-1];
    logic          dout_valid;
    logic          dout_sop;
    logic [4:0]    dout_exp;
    logic          blk_err;

    typedef struct {
        string nm;
        int    fill;
        int    sp_val;
        int    sp_lane;
        int    sp_beat;
        int    ex;
        int    out_fill;
        int    out_sp;
    } vec_t;

    typedef struct {
        int            cyc;
        bit            sop;
        int            ex;
        logic [L*OW-1:0] re;
        logic [L*OW-1:0] im;
    } exp_t;

    exp_t q[$];
    vec_t vecs [7];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   out_seen = 0;
    int   err_pulses = 0;

    cbfp_pack dut (
        .clk        (clk),
        .rstn       (rstn),
        .din_re     (din_re),
        .din_im     (din_im),
        .din_valid  (din_valid),
        .dout_re    (dout_re),
        .dout_im    (dout_im),
        .dout_valid (dout_valid),
        .dout_sop   (dout_sop),
        .dout_exp   (dout_exp),
        .blk_err    (blk_err)
    );

    initial forever #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input longint act, input longint expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, expv);
        end
    endtask

    task automatic chkv(input string nm, input logic [L*OW-1:0] act, input logic [L*OW-1:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, expv);
        end
    endtask

    // Scoreboard: every valid output beat is matched against the oldest expectation
    logic [L*OW-1:0] mon_re;
    logic [L*OW-1:0] mon_im;
    exp_t            mon_e;
    always @(negedge clk) begin
        if (blk_err === 1'b1) err_pulses++;
        if (dout_valid === 1'b1) begin
            out_seen++;
            chk("queue_nonempty", (q.size() > 0) ? 1 : 0, 1);
            if (q.size() > 0) begin
                mon_e = q.pop_front();
                for (int l = 0; l < L; l++) begin
                    mon_re[l*OW +: OW] = dout_re[l];
                    mon_im[l*OW +: OW] = dout_im[l];
                end
                chk("out_cycle", cyc, mon_e.cyc);
                chk("dout_sop", dout_sop, mon_e.sop);
                chk("dout_exp", dout_exp, mon_e.ex);
                chkv("dout_re", mon_re, mon_e.re);
                chkv("dout_im", mon_im, mon_e.im);
            end
        end
    end

    task automatic drive_beat(input vec_t v, input int b, input bit push);
        exp_t e;
        @(negedge clk);
        #1;
        din_valid = 1'b1;
        for (int l = 0; l < L; l++) begin
            din_re[l] = IW'(v.fill);
            din_im[l] = IW'(v.fill);
            e.re[l*OW +: OW] = OW'(v.out_fill);
            e.im[l*OW +: OW] = OW'(v.out_fill);
        end
        if (b == v.sp_beat) begin
            din_re[v.sp_lane] = IW'(v.sp_val);
            e.re[v.sp_lane*OW +: OW] = OW'(v.out_sp);
        end
        e.cyc = cyc + 1 + LAT;
        e.sop = (b == 0);
        e.ex  = v.ex;
        if (push) q.push_back(e);
    endtask

    task automatic drive_block(input vec_t v);
        for (int b = 0; b < B; b++) drive_beat(v, b, 1'b1);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            #1;
            din_valid = 1'b0;
        end
    endtask

    task automatic wait_drain(input int budget);
        int n;
        n = 0;
        while (q.size() != 0 && n < budget) begin
            @(negedge clk);
            #1;
            din_valid = 1'b0;
            n++;
        end
        chk("drain_pending", q.size(), 0);
    endtask

    task automatic wait_out(input int target, input int budget);
        int n;
        n = 0;
        while (out_seen < target && n < budget) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk("outputs_seen", out_seen >= target ? 1 : 0, 1);
    endtask

    initial begin
        int base;
        logic [L*OW-1:0] flat;

        vecs[0] = '{"pos1000", 1000, 1000, 0, 0, 12, 1000, 1000};
        vecs[1] = '{"negfull", 0, -4194304, 5, 0, 0, 0, -1024};
        vecs[2] = '{"zero", 0, 0, 0, 0, 22, 0, 0};
        vecs[3] = '{"max6143", 0, 6143, 3, 2, 9, 0, R6143};
        vecs[4] = '{"pos_sat", 0, 4194303, 15, 3, 0, 0, 1023};
        vecs[5] = '{"neg1000", -1000, -1000, 0, 0, 12, -1000, -1000};
        vecs[6] = '{"mix", 100, 6143, 7, 3, 9, R100, R6143};

        for (int l = 0; l < L; l++) begin
            din_re[l] = '0;
            din_im[l] = '0;
        end

        // Reset state
        repeat (3) @(negedge clk);
        #1;
        chk("rst_valid", dout_valid, 0);
        chk("rst_sop", dout_sop, 0);
        chk("rst_exp", dout_exp, 0);
        chk("rst_blk_err", blk_err, 0);
        chk("rst_dout_re0", dout_re[0], 0);
        rstn = 1'b0;
        idle(2);

        // Isolated blocks from the table
        for (int i = 0; i < 7; i++) begin
            drive_block(vecs[i]);
            idle(1);
            wait_drain(20);
            idle(2);
        end

        // Three back-to-back blocks: contiguous output, exponents 12, 9, 22
        drive_block(vecs[0]);
        drive_block(vecs[3]);
        drive_block(vecs[2]);
        idle(1);
        wait_drain(30);
        idle(2);

        // Truncated block: single error pulse, no output
        chk("no_err_before_trunc", err_pulses, 0);
        base = out_seen;
        drive_beat(vecs[0], 0, 1'b0);
        drive_beat(vecs[0], 1, 1'b0);
        idle(12);
        chk("blk_err_pulses", err_pulses, 1);
        chk("trunc_no_output", out_seen, base);

        // Reset during drain
        base = out_seen;
        drive_block(vecs[0]);
        idle(1);
        wait_out(base + 2, 20);
        rstn = 1'b1;
        @(negedge clk);
        #1;
        for (int l = 0; l < L; l++) flat[l*OW +: OW] = dout_re[l];
        chk("mid_rst_valid", dout_valid, 0);
        chk("mid_rst_sop", dout_sop, 0);
        chk("mid_rst_exp", dout_exp, 0);
        chkv("mid_rst_dout_re", flat, '0);
        q.delete();
        rstn = 1'b0;
        idle(2);
        chk("post_rst_valid", dout_valid, 0);

        // Normal processing after reset
        drive_block(vecs[6]);
        idle(1);
        wait_drain(20);
        idle(3);
        chk("blk_err_total", err_pulses, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
